// File: rtl/ram_line_port_if.sv
// Core-side load/store handshake of ram_line_port.
// The master drives requests; the slave returns one response per accepted request.
interface ram_line_port_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ram_line_port.sv
// Single-line write-back buffer between the core's word port and the 4096-bit line RAM.
// Hits answer in one cycle; misses write back a dirty line, then fill with one wide read.
module ram_line_port #(
  parameter int LINE_AW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_line_port_if.slave      core,
  input  logic                flush_valid,
  output logic                flush_done,
  output logic [LINE_AW-1:0]  mem_raddr,
  input  logic [4095:0]       mem_rdata,
  output logic [LINE_AW-1:0]  mem_waddr,
  output logic [4095:0]       mem_wdata,
  output logic                mem_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_WAIT, S_RESP, S_DONE_FLUSH
  } state_t;

  state_t               state_q, state_d;
  logic [4095:0]        line_q, line_d;
  logic [LINE_AW-1:0]   tag_q, tag_d;
  logic                 valid_q, valid_d;
  logic                 dirty_q, dirty_d;
  logic [LINE_AW-1:0]   pend_idx_q, pend_idx_d;
  logic [6:0]           pend_word_q, pend_word_d;
  logic                 pend_we_q, pend_we_d;
  logic [3:0]           pend_be_q, pend_be_d;
  logic [31:0]          pend_wdata_q, pend_wdata_d;
  logic                 pend_flush_q, pend_flush_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;
  logic                 flush_done_q, flush_done_d;
  logic                 mem_we_q, mem_we_d;
  logic [LINE_AW-1:0]   mem_raddr_q, mem_raddr_d;
  logic [LINE_AW-1:0]   mem_waddr_q, mem_waddr_d;

  logic [LINE_AW-1:0]   req_idx;
  logic                 hit;
  logic                 in_wait;
  logic [6:0]           op_word;
  logic [3:0]           op_be;
  logic [31:0]          op_wdata;
  logic [4095:0]        base_line;
  logic [31:0]          cur_word;
  logic [31:0]          merged_word;
  logic [4095:0]        merged_line;
  logic                 unused_addr;

  assign req_idx     = core.req_addr[9 +: LINE_AW];
  assign unused_addr = ^{core.req_addr[31:9+LINE_AW], core.req_addr[1:0]};
  assign hit         = valid_q && (tag_q == req_idx);

  // One merge datapath serves both a hit (on the held line) and the fill (on mem_rdata).
  always_comb begin
    in_wait   = (state_q == S_WAIT);
    op_word   = in_wait ? pend_word_q : core.req_addr[8:2];
    op_wdata  = in_wait ? pend_wdata_q : core.req_wdata;
    op_be     = in_wait ? (pend_we_q ? pend_be_q : 4'b0000)
                        : (core.req_we ? core.req_be : 4'b0000);
    base_line = in_wait ? mem_rdata : line_q;
    cur_word  = base_line[{op_word, 5'd0} +: 32];
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (op_be[b]) merged_word[8*b +: 8] = op_wdata[8*b +: 8];
    end
    merged_line = base_line;
    merged_line[{op_word, 5'd0} +: 32] = merged_word;
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    pend_idx_d   = pend_idx_q;
    pend_word_d  = pend_word_q;
    pend_we_d    = pend_we_q;
    pend_be_d    = pend_be_q;
    pend_wdata_d = pend_wdata_q;
    pend_flush_d = pend_flush_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    flush_done_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_raddr_d  = mem_raddr_q;
    mem_waddr_d  = mem_waddr_q;

    case (state_q)
      S_IDLE: begin
        if (flush_valid) begin
          pend_flush_d = 1'b1;
          if (valid_q && dirty_q) begin
            state_d     = S_WB;
            mem_we_d    = 1'b1;
            mem_waddr_d = tag_q;
          end else begin
            valid_d      = 1'b0;
            flush_done_d = 1'b1;
          end
        end else if (core.req_valid) begin
          if (hit) begin
            line_d       = merged_line;
            dirty_d      = dirty_q | core.req_we;
            resp_valid_d = 1'b1;
            resp_rdata_d = merged_word;
          end else begin
            pend_idx_d   = req_idx;
            pend_word_d  = core.req_addr[8:2];
            pend_we_d    = core.req_we;
            pend_be_d    = core.req_be;
            pend_wdata_d = core.req_wdata;
            pend_flush_d = 1'b0;
            if (valid_q && dirty_q) begin
              state_d     = S_WB;
              mem_we_d    = 1'b1;
              mem_waddr_d = tag_q;
            end else begin
              state_d     = S_FILL;
              mem_raddr_d = req_idx;
            end
          end
        end
      end
      S_WB: begin
        dirty_d = 1'b0;
        if (pend_flush_q) begin
          state_d      = S_DONE_FLUSH;
          valid_d      = 1'b0;
          flush_done_d = 1'b1;
        end else begin
          state_d     = S_FILL;
          mem_raddr_d = pend_idx_q;
        end
      end
      S_FILL: state_d = S_WAIT;
      S_WAIT: begin
        line_d       = merged_line;
        tag_d        = pend_idx_q;
        valid_d      = 1'b1;
        dirty_d      = pend_we_q;
        resp_valid_d = 1'b1;
        resp_rdata_d = merged_word;
        state_d      = S_RESP;
      end
      S_RESP:       state_d = S_IDLE;
      S_DONE_FLUSH: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      dirty_q      <= 1'b0;
      pend_idx_q   <= '0;
      pend_word_q  <= '0;
      pend_we_q    <= 1'b0;
      pend_be_q    <= '0;
      pend_wdata_q <= '0;
      pend_flush_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      flush_done_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_raddr_q  <= '0;
      mem_waddr_q  <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      pend_idx_q   <= pend_idx_d;
      pend_word_q  <= pend_word_d;
      pend_we_q    <= pend_we_d;
      pend_be_q    <= pend_be_d;
      pend_wdata_q <= pend_wdata_d;
      pend_flush_q <= pend_flush_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      flush_done_q <= flush_done_d;
      mem_we_q     <= mem_we_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_waddr_q  <= mem_waddr_d;
    end
  end

  // Line storage carries no reset; valid_q guards its contents.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign core.req_ready  = rst_n && (state_q == S_IDLE) && !flush_valid;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_rdata = resp_rdata_q;
  assign flush_done      = flush_done_q;
  assign mem_we          = mem_we_q;
  assign mem_raddr       = mem_raddr_q;
  assign mem_waddr       = mem_waddr_q;
  assign mem_wdata       = line_q;

endmodule

// File: tb/tb_ram_line_port.sv
// Directed bench for ram_line_port with a small four-line RAM model (index bits [1:0]).
module tb_ram_line_port;
  logic          clk;
  logic          rst_n;
  logic          flush_valid;
  logic          flush_done;
  logic [7:0]    mem_raddr;
  logic [4095:0] mem_rdata;
  logic [7:0]    mem_waddr;
  logic [4095:0] mem_wdata;
  logic          mem_we;

  ram_line_port_if bus();

  ram_line_port #(.LINE_AW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core        (bus),
    .flush_valid (flush_valid),
    .flush_done  (flush_done),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4095:0] init_line(input logic [1:0] idx);
    logic [4095:0] l;
    l = '0;
    case (idx)
      2'd1: begin
        l[0  +: 32] = 32'h1000_0000;
        l[32 +: 32] = 32'hDEAD_BEEF;
        l[64 +: 32] = 32'hAAAA_AAAA;
        l[96 +: 32] = 32'h3333_3333;
      end
      2'd2: begin
        l[0  +: 32] = 32'h2222_0000;
        l[32 +: 32] = 32'h2222_0001;
      end
      2'd3: l[0 +: 32] = 32'h3333_0000;
      default: l = '0;
    endcase
    return l;
  endfunction

  logic [4095:0] mem [0:3];
  logic [3:0]    wr_flag = 4'b0000;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[1:0]]     <= mem_wdata;
      wr_flag[mem_waddr[1:0]] <= 1'b1;
    end
    mem_rdata <= wr_flag[mem_raddr[1:0]] ? mem[mem_raddr[1:0]] : init_line(mem_raddr[1:0]);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  int          lat;
  int          we_cnt;
  logic [7:0]  we_addr;
  logic [31:0] we_word2;
  logic [31:0] last_rdata;

  // Issue one request, wait for accept, then measure cycles from the accept edge to resp_valid.
  task automatic do_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
    int n;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    lat    = 1;
    we_cnt = 0;
    while (!bus.resp_valid && lat < 12) begin
      if (mem_we) begin
        we_cnt++;
        we_addr  = mem_waddr;
        we_word2 = mem_wdata[64 +: 32];
      end
      @(posedge clk); #1; lat++;
    end
    last_rdata = bus.resp_rdata;
  endtask

  int          flat;
  int          fwe;
  logic [7:0]  fwaddr;
  int          extra;

  initial begin
    rst_n         = 1'b0;
    flush_valid   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    fwaddr        = '0;
    we_addr       = '0;
    we_word2      = '0;
    last_rdata    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);

    // Cold miss load
    do_req(32'h0000_0204, 1'b0, 4'b0000, 32'd0);
    chk("miss_lat", 32'(lat), 32'd3);
    chk("miss_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("miss_raddr", 32'(mem_raddr), 32'h01);
    chk("miss_no_we", 32'(we_cnt), 32'd0);

    // Partial store hit then load back
    do_req(32'h0000_0208, 1'b1, 4'b0101, 32'h1122_3344);
    chk("st_lat", 32'(lat), 32'd1);
    chk("st_rdata", last_rdata, 32'hAA22_AA44);
    do_req(32'h0000_0208, 1'b0, 4'b0000, 32'd0);
    chk("ld_hit_lat", 32'(lat), 32'd1);
    chk("ld_hit_rdata", last_rdata, 32'hAA22_AA44);

    // Back-to-back hits on words 0..3
    begin
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h1000_0000;
      exp_w[1] = 32'hDEAD_BEEF;
      exp_w[2] = 32'hAA22_AA44;
      exp_w[3] = 32'h3333_3333;
      for (int i = 0; i < 4; i++) begin
        bus.req_addr  = 32'h0000_0200 + 32'(4 * i);
        bus.req_we    = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        chk($sformatf("b2b_ready%0d", i), 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        chk($sformatf("b2b_valid%0d", i), 32'(bus.resp_valid), 32'd1);
        chk($sformatf("b2b_rdata%0d", i), bus.resp_rdata, exp_w[i]);
      end
      bus.req_valid = 1'b0;
    end

    // Dirty miss: write-back of line 1, fill of line 2
    do_req(32'h0000_0400, 1'b0, 4'b0000, 32'd0);
    chk("dm_lat", 32'(lat), 32'd4);
    chk("dm_we_cnt", 32'(we_cnt), 32'd1);
    chk("dm_waddr", 32'(we_addr), 32'h01);
    chk("dm_wword", we_word2, 32'hAA22_AA44);
    chk("dm_raddr", 32'(mem_raddr), 32'h02);
    chk("dm_rdata", last_rdata, 32'h2222_0000);

    do_req(32'h0000_0400, 1'b1, 4'b1111, 32'h5566_7788);
    chk("st2_rdata", last_rdata, 32'h5566_7788);

    // Flush and request together while the line is dirty
    bus.req_addr  = 32'h0000_0404;
    bus.req_we    = 1'b0;
    bus.req_be    = 4'b0000;
    bus.req_valid = 1'b1;
    flush_valid   = 1'b1;
    #1;
    chk("fl_ready_low", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    flush_valid = 1'b0;
    flat = 1;
    fwe  = 0;
    while (!flush_done && flat < 10) begin
      if (mem_we) begin
        fwe++;
        fwaddr = mem_waddr;
      end
      @(posedge clk); #1; flat++;
    end
    chk("fl_lat", 32'(flat), 32'd2);
    chk("fl_we_cnt", 32'(fwe), 32'd1);
    chk("fl_waddr", 32'(fwaddr), 32'h02);
    chk("fl_ready_done", 32'(bus.req_ready), 32'd0);
    do_req(32'h0000_0404, 1'b0, 4'b0000, 32'd0);
    chk("fl_req_lat", 32'(lat), 32'd3);
    chk("fl_req_rdata", last_rdata, 32'h2222_0001);
    do_req(32'h0000_0400, 1'b0, 4'b0000, 32'd0);
    chk("wb_refetch_lat", 32'(lat), 32'd1);
    chk("wb_refetch_rdata", last_rdata, 32'h5566_7788);

    // Reset during WAIT of a store miss
    bus.req_addr  = 32'h0000_0600;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'b1111;
    bus.req_wdata = 32'hCAFE_F00D;
    bus.req_valid = 1'b1;
    #1;
    chk("ab_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("ab_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("ab_raddr", 32'(mem_raddr), 32'd0);
    chk("ab_mem_we", 32'(mem_we), 32'd0);
    chk("ab_ready_low", 32'(bus.req_ready), 32'd0);
    chk("ab_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid || mem_we) extra++;
    end
    chk("ab_no_stray", 32'(extra), 32'd0);
    do_req(32'h0000_0600, 1'b0, 4'b0000, 32'd0);
    chk("ab_remiss_lat", 32'(lat), 32'd3);
    chk("ab_remiss_rdata", last_rdata, 32'h3333_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
